// File: rtl/spi_3wire_pkg.sv
// Shared types and helpers for the 3-wire SPI responder.
// State codes and the bit-order helper live here.
package spi_3wire_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_WAIT_CS_HIGH = 2'd0;
  localparam state_t S_IDLE         = 2'd1;
  localparam state_t S_RX           = 2'd2;
  localparam state_t S_TX           = 2'd3;

  // Map an MSB-first bit position to the byte bit that travels there.
  function automatic logic [2:0] bit_idx(
    input logic [2:0] pos,
    input logic       lsb_first
  );
    return lsb_first ? (3'd7 - pos) : pos;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line,
// with one extra flop for rise/fall pulse detection.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Left out of reset so a line held low across reset shows no false edge.
  always_ff @(posedge clk) begin
    chain <= {chain[SYNC_STAGES-2:0], din};
    prev  <= chain[SYNC_STAGES-1];
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral_3wire.sv
// 3-wire SPI responder: oversampled receive path plus
// preloaded response bytes driven on sck falling edges.
module spi_peripheral_3wire
  import spi_3wire_pkg::*;
#(
  parameter int NUM_TX_BYTES  = 4,
  parameter int TX_CNT_SZ     = $clog2(NUM_TX_BYTES + 1),
  parameter int SYNC_STAGES   = 2,
  parameter int READ_FLAG_BIT = 6,
  parameter bit LSB_FIRST     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 cs_n,
  input  logic                 dio_i,
  output logic                 dio_o,
  output logic                 dio_e,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 rx_first,
  output logic                 frame_end,
  output logic                 frame_partial,
  input  logic [7:0]           tx_data [NUM_TX_BYTES],
  input  logic [TX_CNT_SZ-1:0] tx_count,
  output logic                 busy
);

  localparam int IDX_W =
    (NUM_TX_BYTES > 1) ? $clog2(NUM_TX_BYTES) : 1;
  localparam logic [TX_CNT_SZ-1:0] TX_MAX =
    TX_CNT_SZ'(NUM_TX_BYTES);
  localparam logic [2:0] RD_IDX =
    bit_idx(3'(READ_FLAG_BIT), LSB_FIRST);

  logic unused_sck_level;
  logic sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] dio_chain;
  logic din_s;

  state_t state;
  logic [2:0] bit_cnt;
  logic [2:0] byte_idx;
  logic [7:0] shreg;
  logic [7:0] rx_next;
  logic [7:0] tx_buf [NUM_TX_BYTES];
  logic [TX_CNT_SZ-1:0] r_tx_count;
  logic [TX_CNT_SZ-1:0] tx_idx;
  logic [TX_CNT_SZ-1:0] tx_idx_inc;
  logic [IDX_W-1:0] tx_sel;
  logic [2:0] tx_bit;
  logic tx_live;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk   (clk),
    .din   (sck),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk   (clk),
    .din   (cs_n),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Data line delayed by the same depth as sck so samples line up.
  always_ff @(posedge clk) begin
    dio_chain <= {dio_chain[SYNC_STAGES-2:0], dio_i};
  end

  assign din_s = dio_chain[SYNC_STAGES-1];

  assign rx_next = LSB_FIRST ? {din_s, shreg[7:1]}
                             : {shreg[6:0], din_s};
  assign tx_live    = tx_idx < r_tx_count;
  assign tx_sel     = tx_idx[IDX_W-1:0];
  assign tx_idx_inc = tx_idx + TX_CNT_SZ'(1);

  // Frame state machine: receive, respond, and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_WAIT_CS_HIGH;
      dio_o         <= 1'b1;
      dio_e         <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_first      <= 1'b0;
      frame_end     <= 1'b0;
      frame_partial <= 1'b0;
      busy          <= 1'b0;
      bit_cnt       <= 3'd0;
      byte_idx      <= 3'd0;
      shreg         <= 8'h00;
      r_tx_count    <= '0;
      tx_idx        <= '0;
      tx_bit        <= 3'd7;
    end else begin
      rx_valid      <= 1'b0;
      frame_end     <= 1'b0;
      frame_partial <= 1'b0;
      unique case (state)
        S_WAIT_CS_HIGH: begin
          if (cs_s) state <= S_IDLE;
        end
        S_IDLE: begin
          busy  <= 1'b0;
          dio_e <= 1'b0;
          dio_o <= 1'b1;
          if (cs_fall) begin
            state    <= S_RX;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            busy     <= 1'b1;
          end
        end
        S_RX: begin
          if (sck_rise) begin
            shreg   <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              rx_first <= (byte_idx == 3'd0);
              if (byte_idx != 3'd7)
                byte_idx <= byte_idx + 3'd1;
              if (byte_idx == 3'd0 && rx_next[RD_IDX]) begin
                for (int i = 0; i < NUM_TX_BYTES; i++)
                  tx_buf[i] <= tx_data[i];
                r_tx_count <= (tx_count > TX_MAX) ? TX_MAX
                                                  : tx_count;
                tx_idx <= '0;
                tx_bit <= 3'd7;
                state  <= S_TX;
              end
            end
          end
          if (cs_rise) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            dio_e         <= 1'b0;
            dio_o         <= 1'b1;
            frame_end     <= 1'b1;
            frame_partial <= sck_rise ? (bit_cnt != 3'd7)
                                      : (bit_cnt != 3'd0);
          end
        end
        S_TX: begin
          if (sck_fall) begin
            if (tx_live) begin
              dio_e <= 1'b1;
              dio_o <= tx_buf[tx_sel][bit_idx(tx_bit, LSB_FIRST)];
            end else begin
              dio_e <= 1'b0;
              dio_o <= 1'b1;
            end
          end
          if (sck_rise && tx_live) begin
            if (tx_bit == 3'd0) begin
              tx_idx <= tx_idx_inc;
              tx_bit <= 3'd7;
              if (tx_idx_inc == r_tx_count) begin
                dio_e <= 1'b0;
                dio_o <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit - 3'd1;
            end
          end
          if (cs_rise) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            dio_e         <= 1'b0;
            dio_o         <= 1'b1;
            frame_end     <= 1'b1;
            frame_partial <= (tx_bit != 3'd0) && (tx_bit != 3'd7);
          end
        end
        default: state <= S_WAIT_CS_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral_3wire.sv
// Directed bench for spi_peripheral_3wire: one MSB-first
// instance and one LSB-first instance on a shared sck/dio.
module tb_spi_peripheral_3wire;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int HP = 80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b1;
  logic cs0_n = 1'b1;
  logic cs1_n = 1'b1;
  logic dio_i = 1'b1;

  logic dio_o0, dio_e0, rx_valid0, rx_first0;
  logic frame_end0, frame_partial0, busy0;
  logic [7:0] rx_data0;
  logic dio_o1, dio_e1, rx_valid1, rx_first1;
  logic frame_end1, frame_partial1, busy1;
  logic [7:0] rx_data1;
  logic [7:0] tx0 [N];
  logic [7:0] tx1 [N];
  logic [CW-1:0] cnt0 = '0;
  logic [CW-1:0] cnt1 = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] rx0_q[$];
  bit rf0_q[$];
  int fe0, fp0;
  bit de0_seen;
  logic [7:0] rx1_q[$];
  bit rf1_q[$];
  int fe1;
  bit de1_seen;

  always #5 clk = ~clk;

  spi_peripheral_3wire #(.NUM_TX_BYTES(N)) dut0 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs0_n),
    .dio_i(dio_i), .dio_o(dio_o0), .dio_e(dio_e0),
    .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_first(rx_first0), .frame_end(frame_end0),
    .frame_partial(frame_partial0), .tx_data(tx0),
    .tx_count(cnt0), .busy(busy0)
  );

  spi_peripheral_3wire #(.NUM_TX_BYTES(N), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs1_n),
    .dio_i(dio_i), .dio_o(dio_o1), .dio_e(dio_e1),
    .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_first(rx_first1), .frame_end(frame_end1),
    .frame_partial(frame_partial1), .tx_data(tx1),
    .tx_count(cnt1), .busy(busy1)
  );

  // Event recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid0) begin
      rx0_q.push_back(rx_data0);
      rf0_q.push_back(rx_first0);
    end
    if (frame_end0) begin
      fe0++;
      fp0 += int'(frame_partial0);
    end
    if (dio_e0) de0_seen = 1'b1;
    if (rx_valid1) begin
      rx1_q.push_back(rx_data1);
      rf1_q.push_back(rx_first1);
    end
    if (frame_end1) fe1++;
    if (dio_e1) de1_seen = 1'b1;
  end

  task automatic clear_log();
    rx0_q.delete(); rf0_q.delete();
    rx1_q.delete(); rf1_q.delete();
    fe0 = 0; fp0 = 0; fe1 = 0;
    de0_seen = 1'b0; de1_seen = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n,
                           input bit lsb);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      dio_i = lsb ? b[i] : b[7-i];
      #(HP);
      sck = 1'b1;
      #(HP);
    end
  endtask

  task automatic read_byte(input bit sel, input bit lsb,
                           output logic [7:0] b, output bit en_ok);
    logic d, e;
    b = 8'h00;
    en_ok = 1'b1;
    dio_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0;
      #(HP);
      d = sel ? dio_o1 : dio_o0;
      e = sel ? dio_e1 : dio_e0;
      if (!e) en_ok = 1'b0;
      if (lsb) b[i] = d;
      else b[7-i] = d;
      sck = 1'b1;
      #(HP);
    end
  endtask

  task automatic test_reset();
    logic [6:0] v;
    v = {dio_o0, dio_e0, rx_valid0, rx_first0,
         frame_end0, frame_partial0, busy0};
    n_checks++;
    if (v !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctl0: got %b want 1000000", v);
    end
    n_checks++;
    if (rx_data0 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx0: got %h want 00", rx_data0);
    end
    v = {dio_o1, dio_e1, rx_valid1, rx_first1,
         frame_end1, frame_partial1, busy1};
    n_checks++;
    if (v !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctl1: got %b want 1000000", v);
    end
  endtask

  task automatic test_write();
    logic [7:0] exp_d [3];
    bit exp_f [3];
    exp_d = '{8'h80, 8'h12, 8'hAB};
    exp_f = '{1'b1, 1'b0, 1'b0};
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'h80, 8, 1'b0);
    #2000;
    send_bits(8'h12, 8, 1'b0);
    #2000;
    send_bits(8'hAB, 8, 1'b0);
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy: got %b want 1", busy0);
    end
    #(HP);
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (rx0_q.size() != 3) begin
      n_fail++;
      $display("FAIL wr_count: got %0d want 3", rx0_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx0_q[i] !== exp_d[i] || rf0_q[i] !== exp_f[i]) begin
          n_fail++;
          $display("FAIL wr_byte%0d: got %h/%b want %h/%b", i,
                   rx0_q[i], rf0_q[i], exp_d[i], exp_f[i]);
        end
      end
    end
    n_checks++;
    if (fe0 != 1 || fp0 != 0 || busy0 !== 1'b0 || de0_seen) begin
      n_fail++;
      $display("FAIL wr_end: got fe=%0d fp=%0d busy=%b de=%b want 1 0 0 0",
               fe0, fp0, busy0, de0_seen);
    end
  endtask

  task automatic test_read();
    logic [7:0] b;
    bit e;
    tx0[0] = 8'hA5; tx0[1] = 8'h3C;
    tx0[2] = 8'h00; tx0[3] = 8'h00;
    cnt0 = 3'd2;
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'h41, 8, 1'b0);
    read_byte(1'b0, 1'b0, b, e);
    n_checks++;
    if (b !== 8'hA5 || !e) begin
      n_fail++;
      $display("FAIL rd_byte0: got %h en=%b want a5 en=1", b, e);
    end
    read_byte(1'b0, 1'b0, b, e);
    n_checks++;
    if (b !== 8'h3C || !e) begin
      n_fail++;
      $display("FAIL rd_byte1: got %h en=%b want 3c en=1", b, e);
    end
    n_checks++;
    if (dio_e0 !== 1'b0 || dio_o0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_release: got e=%b o=%b want 0 1",
               dio_e0, dio_o0);
    end
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (dio_e0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_cs_release: got %b want 0", dio_e0);
    end
    n_checks++;
    if (rx0_q.size() != 1 || rx0_q[0] !== 8'h41 || !rf0_q[0]) begin
      n_fail++;
      $display("FAIL rd_cmd: got n=%0d want one 41 first",
               rx0_q.size());
    end
    n_checks++;
    if (fe0 != 1 || fp0 != 0) begin
      n_fail++;
      $display("FAIL rd_end: got fe=%0d fp=%0d want 1 0", fe0, fp0);
    end
  endtask

  task automatic test_partial();
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'h80, 8, 1'b0);
    send_bits(8'h12, 5, 1'b0);
    #(HP);
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (rx0_q.size() != 1 || rx0_q[0] !== 8'h80) begin
      n_fail++;
      $display("FAIL part_rx: got n=%0d want one 80", rx0_q.size());
    end
    n_checks++;
    if (fe0 != 1 || fp0 != 1) begin
      n_fail++;
      $display("FAIL part_end: got fe=%0d fp=%0d want 1 1", fe0, fp0);
    end
    n_checks++;
    if (dio_e0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL part_idle: got e=%b busy=%b want 0 0",
               dio_e0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    cnt0 = 3'd0;
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'hC3, 3, 1'b0);
    reset = 1'b1;
    #30;
    reset = 1'b0;
    #20;
    n_checks++;
    if (busy0 !== 1'b0 || dio_e0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got busy=%b e=%b want 0 0",
               busy0, dio_e0);
    end
    send_bits(8'hC3, 5, 1'b0);
    send_bits(8'h99, 8, 1'b0);
    #(HP);
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (rx0_q.size() != 0 || fe0 != 0) begin
      n_fail++;
      $display("FAIL rstmid_ignored: got rx=%0d fe=%0d want 0 0",
               rx0_q.size(), fe0);
    end
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'h55, 8, 1'b0);
    #(HP);
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (rx0_q.size() != 1 || rx0_q[0] !== 8'h55 || !rf0_q[0]) begin
      n_fail++;
      $display("FAIL rstmid_next: got n=%0d want one 55 first",
               rx0_q.size());
    end
    n_checks++;
    if (fe0 != 1 || fp0 != 0) begin
      n_fail++;
      $display("FAIL rstmid_end: got fe=%0d fp=%0d want 1 0", fe0, fp0);
    end
  endtask

  task automatic test_tx_zero();
    logic [7:0] b;
    bit e;
    cnt0 = 3'd0;
    clear_log();
    cs0_n = 1'b0;
    #(HP);
    send_bits(8'h40, 8, 1'b0);
    read_byte(1'b0, 1'b0, b, e);
    read_byte(1'b0, 1'b0, b, e);
    #(HP);
    cs0_n = 1'b1;
    #300;
    n_checks++;
    if (rx0_q.size() != 1 || rx0_q[0] !== 8'h40) begin
      n_fail++;
      $display("FAIL tx0_cmd: got n=%0d want one 40", rx0_q.size());
    end
    n_checks++;
    if (de0_seen || b !== 8'hFF) begin
      n_fail++;
      $display("FAIL tx0_quiet: got de=%b line=%h want 0 ff",
               de0_seen, b);
    end
    n_checks++;
    if (fe0 != 1 || fp0 != 0) begin
      n_fail++;
      $display("FAIL tx0_end: got fe=%0d fp=%0d want 1 0", fe0, fp0);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] b;
    bit e;
    tx1[0] = 8'h01; tx1[1] = 8'h00;
    tx1[2] = 8'h00; tx1[3] = 8'h00;
    cnt1 = 3'd1;
    clear_log();
    cs1_n = 1'b0;
    #(HP);
    send_bits(8'h02, 8, 1'b1);
    read_byte(1'b1, 1'b1, b, e);
    n_checks++;
    if (b !== 8'h01 || !e) begin
      n_fail++;
      $display("FAIL lsb_tx: got %h en=%b want 01 en=1", b, e);
    end
    n_checks++;
    if (dio_e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_release: got %b want 0", dio_e1);
    end
    cs1_n = 1'b1;
    #300;
    n_checks++;
    if (rx1_q.size() != 1 || rx1_q[0] !== 8'h02 || !rf1_q[0]) begin
      n_fail++;
      $display("FAIL lsb_rx: got n=%0d want one 02 first",
               rx1_q.size());
    end
    n_checks++;
    if (fe1 != 1) begin
      n_fail++;
      $display("FAIL lsb_end: got fe=%0d want 1", fe1);
    end
    n_checks++;
    if (rx0_q.size() != 0 || fe0 != 0 || de0_seen) begin
      n_fail++;
      $display("FAIL lsb_other_quiet: got rx=%0d fe=%0d de=%b want 0",
               rx0_q.size(), fe0, de0_seen);
    end
  endtask

  task automatic test_idle_sck();
    clear_log();
    for (int i = 0; i < 20; i++) begin
      sck = ~sck;
      dio_i = i[0];
      #(HP);
    end
    #300;
    n_checks++;
    if (rx0_q.size() != 0 || fe0 != 0 || de0_seen || busy0) begin
      n_fail++;
      $display("FAIL idle0: got rx=%0d fe=%0d de=%b busy=%b want 0",
               rx0_q.size(), fe0, de0_seen, busy0);
    end
    n_checks++;
    if (rx1_q.size() != 0 || fe1 != 0 || de1_seen) begin
      n_fail++;
      $display("FAIL idle1: got rx=%0d fe=%0d de=%b want 0",
               rx1_q.size(), fe1, de1_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tx0[i] = 8'h00;
      tx1[i] = 8'h00;
    end
    clear_log();
    #103;
    reset = 1'b0;
    #20;
    test_reset();
    test_write();
    test_read();
    test_partial();
    test_reset_mid();
    test_tx_zero();
    test_lsb_first();
    test_idle_sck();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
